// File: rtl/sync_mem_pkg.sv
// Shared types and helpers for the synchronous-memory stream writer.
package sync_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        CLEAR
    } state_t;

    // Next address with wrap at depth-1; works for non-power-of-two depths.
    function automatic int unsigned wrap_inc(input int unsigned addr, input int unsigned depth);
        return (addr >= depth - 1) ? 0 : addr + 1;
    endfunction

    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned depth);
        return (len > depth) ? depth : len;
    endfunction

endpackage

// File: rtl/sync_mem_stream_writer_if.sv
// Command, stream and memory-write-port signals of the stream writer.
interface sync_mem_stream_writer_if #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned AW    = 2
);
    logic             START_WRITE;
    logic             START_CLEAR;
    logic [AW-1:0]    START_ADDR;
    logic [AW:0]      LEN;
    logic [WIDTH-1:0] FILL_VALUE;
    logic [WIDTH-1:0] IN_DATA;
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] WDATA;
    logic [AW-1:0]    WADDR;
    logic             WEN;
    logic             BUSY;
    logic             DONE;

    modport master (
        output START_WRITE, START_CLEAR, START_ADDR, LEN, FILL_VALUE, IN_DATA, IN_VALID,
        input  IN_READY, WDATA, WADDR, WEN, BUSY, DONE
    );

    modport slave (
        input  START_WRITE, START_CLEAR, START_ADDR, LEN, FILL_VALUE, IN_DATA, IN_VALID,
        output IN_READY, WDATA, WADDR, WEN, BUSY, DONE
    );
endinterface

// File: rtl/mem_addr_counter.sv
// Loadable, enableable counter: up-count wraps at DEPTH-1, down-count flags the last unit.
module mem_addr_counter
    import sync_mem_pkg::*;
#(
    parameter int unsigned W     = 2,
    parameter int unsigned DEPTH = 4,
    parameter bit          DOWN  = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         tc
);
    logic [W-1:0] count_next;

    always_comb begin
        count_next = count - W'(1);
        if (!DOWN) begin
            count_next = W'(wrap_inc(32'(count), DEPTH));
        end
    end

    // Up: at the wrap point. Down: one unit left, so the enabled step is the final one.
    assign tc = DOWN ? (count == W'(1)) : (32'(count) == DEPTH - 1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= count_next;
        end
    end
endmodule

// File: rtl/sync_mem_stream_writer.sv
// Write-side controller: streams words to consecutive wrapping addresses or clears the array.
module sync_mem_stream_writer
    import sync_mem_pkg::*;
#(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input logic                     CLK,
    input logic                     RESETN,
    sync_mem_stream_writer_if.slave bus
);
    state_t           state, next_state;
    logic [AW-1:0]    addr, addr_ld_val, start_addr_ok;
    logic [AW:0]      rem, rem_ld_val;
    logic             addr_tc, rem_tc;
    logic             cnt_load, cnt_en, wr, finish;
    logic [WIDTH-1:0] wr_data, fill_q;
    logic             unused_cnt;

    assign start_addr_ok = (32'(bus.START_ADDR) >= DEPTH) ? '0 : bus.START_ADDR;
    assign unused_cnt    = ^{addr_tc, rem};

    mem_addr_counter #(.W(AW), .DEPTH(DEPTH), .DOWN(1'b0)) u_addr (
        .clk(CLK), .rst_n(RESETN), .load(cnt_load), .load_val(addr_ld_val),
        .en(cnt_en), .count(addr), .tc(addr_tc)
    );

    mem_addr_counter #(.W(AW + 1), .DEPTH(DEPTH), .DOWN(1'b1)) u_rem (
        .clk(CLK), .rst_n(RESETN), .load(cnt_load), .load_val(rem_ld_val),
        .en(cnt_en), .count(rem), .tc(rem_tc)
    );

    always_comb begin
        next_state  = state;
        cnt_load    = 1'b0;
        cnt_en      = 1'b0;
        addr_ld_val = '0;
        rem_ld_val  = '0;
        wr          = 1'b0;
        wr_data     = bus.IN_DATA;
        finish      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.START_CLEAR) begin
                    next_state = CLEAR;
                    cnt_load   = 1'b1;
                    rem_ld_val = (AW + 1)'(DEPTH);
                end else if (bus.START_WRITE) begin
                    if (bus.LEN == '0) begin
                        finish = 1'b1;
                    end else begin
                        next_state  = STREAM;
                        cnt_load    = 1'b1;
                        addr_ld_val = start_addr_ok;
                        rem_ld_val  = (AW + 1)'(clamp_len(32'(bus.LEN), DEPTH));
                    end
                end
            end
            STREAM: begin
                if (bus.IN_VALID) begin
                    wr     = 1'b1;
                    cnt_en = 1'b1;
                    if (rem_tc) begin
                        next_state = IDLE;
                        finish     = 1'b1;
                    end
                end
            end
            CLEAR: begin
                wr      = 1'b1;
                wr_data = fill_q;
                cnt_en  = 1'b1;
                if (rem_tc) begin
                    next_state = IDLE;
                    finish     = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // DONE and the final WEN come from the same edge that returns the FSM to IDLE.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            bus.WEN   <= 1'b0;
            bus.DONE  <= 1'b0;
            bus.WADDR <= '0;
            bus.WDATA <= '0;
            fill_q    <= '0;
        end else begin
            bus.WEN  <= wr;
            bus.DONE <= finish;
            if (wr) begin
                bus.WADDR <= addr;
                bus.WDATA <= wr_data;
            end
            if (state == IDLE && bus.START_CLEAR) begin
                fill_q <= bus.FILL_VALUE;
            end
        end
    end

    assign bus.BUSY     = (state != IDLE);
    assign bus.IN_READY = (state == STREAM);
endmodule

// File: tb/tb_sync_mem_stream_writer.sv
// Scoreboard bench for sync_mem_stream_writer (WIDTH=5, DEPTH=4) with a memory model attached.
module tb_sync_mem_stream_writer;
    typedef struct {
        int         cyc;
        logic       wen;
        logic [2:0] addr;
        logic [4:0] data;
        logic       done;
    } exp_t;

    logic CLK = 1'b0;
    logic RESETN;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t q[$];
    exp_t mon_e;
    exp_t stim_e;
    logic [4:0] mem [0:7];

    sync_mem_stream_writer_if #(.WIDTH(5), .AW(3)) bus ();

    sync_mem_stream_writer #(.WIDTH(5), .DEPTH(4), .AW(3)) dut (
        .CLK(CLK),
        .RESETN(RESETN),
        .bus(bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Memory primitive: commits on the edge after WEN is seen.
    always @(posedge CLK) begin
        if (bus.WEN === 1'b1) mem[bus.WADDR] <= bus.WDATA;
    end

    // Monitor: every WEN or DONE cycle must match the oldest expectation.
    always @(negedge CLK) begin
        if (bus.WEN === 1'b1 || bus.DONE === 1'b1) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_output: cyc=%0d wen=%b done=%b waddr=%0d wdata=%0d, required no output",
                         cyc, bus.WEN, bus.DONE, bus.WADDR, bus.WDATA);
            end else begin
                mon_e = q.pop_front();
                if (cyc != mon_e.cyc || bus.WEN !== mon_e.wen || bus.DONE !== mon_e.done ||
                    (mon_e.wen && (bus.WADDR !== mon_e.addr || bus.WDATA !== mon_e.data))) begin
                    bad++;
                    $display("FAIL write_check: got cyc=%0d wen=%b done=%b waddr=%0d wdata=%0d, expected cyc=%0d wen=%b done=%b waddr=%0d wdata=%0d",
                             cyc, bus.WEN, bus.DONE, bus.WADDR, bus.WDATA,
                             mon_e.cyc, mon_e.wen, mon_e.done, mon_e.addr, mon_e.data);
                end
            end
        end
        if (q.size() != 0 && q[0].cyc < cyc) begin
            total++;
            bad++;
            $display("FAIL missing_output: got nothing at cyc=%0d, expected waddr=%0d wdata=%0d done=%b",
                     q[0].cyc, q[0].addr, q[0].data, q[0].done);
            void'(q.pop_front());
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic start_write(input logic [2:0] a, input logic [3:0] l);
        bus.START_WRITE = 1'b1;
        bus.START_ADDR  = a;
        bus.LEN         = l;
        @(negedge CLK);
        bus.START_WRITE = 1'b0;
        check("busy_after_start", 8'(bus.BUSY), 8'd1);
    endtask

    task automatic send(input logic [4:0] d, input logic [2:0] a, input logic last);
        exp_t e;
        check("in_ready_stream", 8'(bus.IN_READY), 8'd1);
        bus.IN_VALID = 1'b1;
        bus.IN_DATA  = d;
        e.cyc  = cyc + 1;
        e.wen  = 1'b1;
        e.addr = a;
        e.data = d;
        e.done = last;
        q.push_back(e);
        @(negedge CLK);
        bus.IN_VALID = 1'b0;
    endtask

    initial begin
        RESETN          = 1'b0;
        bus.START_WRITE = 1'b0;
        bus.START_CLEAR = 1'b0;
        bus.START_ADDR  = '0;
        bus.LEN         = '0;
        bus.FILL_VALUE  = '0;
        bus.IN_DATA     = '0;
        bus.IN_VALID    = 1'b0;
        idle(3);
        check("reset_wen", 8'(bus.WEN), 8'd0);
        check("reset_waddr", 8'(bus.WADDR), 8'd0);
        check("reset_wdata", 8'(bus.WDATA), 8'd0);
        check("reset_busy", 8'(bus.BUSY), 8'd0);
        check("reset_done", 8'(bus.DONE), 8'd0);
        check("reset_in_ready", 8'(bus.IN_READY), 8'd0);
        RESETN = 1'b1;
        idle(1);

        // Basic back-to-back burst
        start_write(3'd0, 4'd4);
        send(5'd5, 3'd0, 1'b0);
        send(5'd0, 3'd1, 1'b0);
        send(5'd21, 3'd2, 1'b0);
        send(5'd11, 3'd3, 1'b1);
        idle(2);
        check("basic_mem0", 8'(mem[0]), 8'd5);
        check("basic_mem1", 8'(mem[1]), 8'd0);
        check("basic_mem2", 8'(mem[2]), 8'd21);
        check("basic_mem3", 8'(mem[3]), 8'd11);
        check("basic_busy_end", 8'(bus.BUSY), 8'd0);

        // Wrap-around with 2-cycle stalls
        start_write(3'd3, 4'd3);
        send(5'd7, 3'd3, 1'b0);
        idle(2);
        send(5'd8, 3'd0, 1'b0);
        idle(2);
        send(5'd9, 3'd1, 1'b1);
        idle(2);
        check("wrap_mem3", 8'(mem[3]), 8'd7);
        check("wrap_mem0", 8'(mem[0]), 8'd8);
        check("wrap_mem1", 8'(mem[1]), 8'd9);
        check("wrap_mem2_kept", 8'(mem[2]), 8'd21);

        // Clear wins over a simultaneous write request; fill sampled at start
        bus.START_CLEAR = 1'b1;
        bus.START_WRITE = 1'b1;
        bus.FILL_VALUE  = 5'd31;
        bus.LEN         = 4'd2;
        bus.START_ADDR  = 3'd1;
        for (int i = 0; i < 4; i++) begin
            stim_e = '{cyc: cyc + 2 + i, wen: 1'b1, addr: 3'(i), data: 5'd31, done: (i == 3)};
            q.push_back(stim_e);
        end
        @(negedge CLK);
        bus.START_CLEAR = 1'b0;
        bus.START_WRITE = 1'b0;
        bus.FILL_VALUE  = 5'd3;
        bus.IN_VALID    = 1'b1;
        bus.IN_DATA     = 5'd17;
        for (int i = 0; i < 4; i++) begin
            check("clear_in_ready", 8'(bus.IN_READY), 8'd0);
            check("clear_busy", 8'(bus.BUSY), 8'd1);
            @(negedge CLK);
        end
        bus.IN_VALID = 1'b0;
        idle(2);
        for (int i = 0; i < 4; i++) check("clear_mem", 8'(mem[i]), 8'd31);

        // Zero-length burst: DONE only
        bus.START_WRITE = 1'b1;
        bus.LEN         = 4'd0;
        bus.START_ADDR  = 3'd2;
        stim_e = '{cyc: cyc + 1, wen: 1'b0, addr: 3'd0, data: 5'd0, done: 1'b1};
        q.push_back(stim_e);
        @(negedge CLK);
        bus.START_WRITE = 1'b0;
        check("zero_len_busy", 8'(bus.BUSY), 8'd0);
        idle(1);
        check("zero_len_busy2", 8'(bus.BUSY), 8'd0);

        // Start request while busy is ignored
        start_write(3'd1, 4'd3);
        send(5'd4, 3'd1, 1'b0);
        bus.START_WRITE = 1'b1;
        bus.START_ADDR  = 3'd0;
        bus.LEN         = 4'd1;
        @(negedge CLK);
        bus.START_WRITE = 1'b0;
        send(5'd6, 3'd2, 1'b0);
        send(5'd1, 3'd3, 1'b1);
        idle(3);
        check("busy_ignored_idle", 8'(bus.BUSY), 8'd0);

        // Reset after 2 of 4 handshakes
        start_write(3'd0, 4'd4);
        send(5'd2, 3'd0, 1'b0);
        send(5'd3, 3'd1, 1'b0);
        RESETN       = 1'b0;
        bus.IN_VALID = 1'b1;
        bus.IN_DATA  = 5'd9;
        @(negedge CLK);
        check("midrst_wen", 8'(bus.WEN), 8'd0);
        check("midrst_waddr", 8'(bus.WADDR), 8'd0);
        check("midrst_wdata", 8'(bus.WDATA), 8'd0);
        check("midrst_busy", 8'(bus.BUSY), 8'd0);
        check("midrst_done", 8'(bus.DONE), 8'd0);
        check("midrst_in_ready", 8'(bus.IN_READY), 8'd0);
        RESETN       = 1'b1;
        bus.IN_VALID = 1'b0;
        idle(3);
        check("midrst_mem0", 8'(mem[0]), 8'd2);
        check("midrst_mem1", 8'(mem[1]), 8'd3);
        check("midrst_mem2", 8'(mem[2]), 8'd6);
        check("midrst_mem3", 8'(mem[3]), 8'd1);

        // LEN and START_ADDR clamping
        start_write(3'd5, 4'd7);
        send(5'd10, 3'd0, 1'b0);
        send(5'd11, 3'd1, 1'b0);
        send(5'd12, 3'd2, 1'b0);
        send(5'd13, 3'd3, 1'b1);
        check("clamp_ready_after", 8'(bus.IN_READY), 8'd0);
        bus.IN_VALID = 1'b1;
        bus.IN_DATA  = 5'd30;
        @(negedge CLK);
        bus.IN_VALID = 1'b0;
        idle(2);
        for (int i = 0; i < 4; i++) check("clamp_mem", 8'(mem[i]), 8'(10 + i));

        idle(3);
        check("queue_drained", 8'(q.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
